// File: rtl/conv1_frame_ctrl.sv
// conv1 frame sequencer: streams one IMG_W x IMG_H image from memory into conv1,
// then counts and tags the qualified conv1 output beats until the frame completes.
module conv1_frame_ctrl #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 5,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 10,
    parameter int DRAIN_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              img_rdy,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    input  logic [PIX_W-1:0]  img_rd_data,
    output logic [PIX_W-1:0]  cnn_data_in,
    output logic              cnn_data_in_valid,
    input  logic              conv_out_valid,
    output logic              out_beat,
    output logic [4:0]        out_x,
    output logic [4:0]        out_y,
    output logic [9:0]        out_cnt,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_err
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [9:0] OUT_N = 10'(OUT_W * OUT_H);
    localparam logic [4:0] X_LAST = 5'(OUT_W - 1);
    localparam logic [4:0] Y_LAST = 5'(OUT_H - 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DW-1:0]     drain_cnt;
    logic              vld_p1, vld_p2, vld_p3;
    logic [PIX_W-1:0]  pix_p1;
    logic [9:0]        cnt_nxt;
    logic              start_frame, err_set, adv, overrun;

    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic beat);
        return (beat && v != OUT_N) ? v + 10'd1 : v;
    endfunction

    assign img_rd_en         = (state == FEED) && img_rdy && !abort;
    assign img_rd_addr       = ptr;
    assign cnn_data_in_valid = vld_p1 && !abort;
    assign cnn_data_in       = cnn_data_in_valid ? img_rd_data : pix_p1;
    assign out_beat          = conv_out_valid && vld_p3;
    assign frame_busy        = (state != IDLE);
    assign frame_done        = (state == DONE);
    assign cnt_nxt           = sat_inc(out_cnt, out_beat);
    assign adv               = out_beat && (out_cnt != OUT_N);
    assign overrun           = out_beat && (out_cnt == OUT_N);

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = FEED;
                    start_frame = 1'b1;
                end
            end
            FEED: begin
                if (img_rd_en && ptr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt_nxt == OUT_N) begin
                    state_nxt = DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                    err_set   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort outranks start and any completion in the same cycle
        if (abort) begin
            state_nxt   = IDLE;
            start_frame = 1'b0;
            err_set     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            if (start_frame)
                ptr <= '0;
            else if (img_rd_en)
                ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
        end
    end

    // p1: memory read data returns; p2/p3: match conv1's fixed 2-cycle output latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= img_rd_en;
            vld_p2 <= cnn_data_in_valid;
            vld_p3 <= abort ? 1'b0 : vld_p2;
            if (cnn_data_in_valid) pix_p1 <= img_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            frame_err <= 1'b0;
        end else if (start_frame) begin
            out_cnt   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            frame_err <= 1'b0;
        end else begin
            out_cnt <= cnt_nxt;
            if (adv) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_LAST) ? 5'd0 : out_y + 5'd1;
                end else begin
                    out_x <= out_x + 5'd1;
                end
            end
            if (err_set || overrun) frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Scoreboard bench for conv1_frame_ctrl with image memory and conv1 latency models.
module tb_conv1_frame_ctrl;
    localparam int IMG_W = 28, IMG_H = 28, K = 5, PIX_W = 8, ADDR_W = 10, DRAIN_MAX = 8;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int OW = IMG_W - K + 1;
    localparam int NOUT = OW * (IMG_H - K + 1);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, img_rdy = 1'b0;
    logic img_rd_en, cnn_data_in_valid, out_beat, frame_busy, frame_done, frame_err;
    logic [ADDR_W-1:0] img_rd_addr;
    logic [PIX_W-1:0] img_rd_data = '0, cnn_data_in;
    logic conv_out_valid;
    logic [4:0] out_x, out_y;
    logic [9:0] out_cnt;
    logic [43:0] outs;

    conv1_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W),
                       .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .img_rdy(img_rdy),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
        .cnn_data_in(cnn_data_in), .cnn_data_in_valid(cnn_data_in_valid),
        .conv_out_valid(conv_out_valid), .out_beat(out_beat), .out_x(out_x), .out_y(out_y),
        .out_cnt(out_cnt), .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    assign outs = {img_rd_en, img_rd_addr, cnn_data_in, cnn_data_in_valid, out_beat,
                   out_x, out_y, out_cnt, frame_busy, frame_done, frame_err};

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [PIX_W-1:0] ram [NPIX];
    always @(posedge clk) if (img_rd_en) img_rd_data <= ram[int'(img_rd_addr) % NPIX];

    // conv1 model: 2-cycle latency, fires on pixels completing a KxK window
    int conv_mode = 0;
    bit spur_en = 1'b0, model_rst = 1'b0;
    int pix_idx = 0, qual_n = 0, gen = 0;
    logic c1 = 1'b0, c2 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [10:0] coord_q[$];
    logic [PIX_W-1:0] pix_q[$];

    function automatic bit qual(input int idx);
        return (idx % IMG_W >= K - 1) && (idx / IMG_W >= K - 1);
    endfunction

    function automatic bit fire(input int idx, input int qn);
        return (qual(idx) && !(conv_mode == 1 && qn >= NOUT - 10)) ||
               (conv_mode == 2 && idx == (K - 1) * IMG_W);
    endfunction

    function automatic logic [10:0] mk_coord(input int g);
        return {g < NOUT, 5'(g / OW), 5'(g % OW)};
    endfunction

    always @(posedge clk) begin
        if (model_rst) begin
            pix_idx <= 0; qual_n <= 0; gen <= 0;
            c1 <= 1'b0; c2 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            v1 <= cnn_data_in_valid;
            v2 <= v1;
            c2 <= c1;
            c1 <= cnn_data_in_valid && fire(pix_idx, qual_n);
            if (cnn_data_in_valid) begin
                pix_idx <= pix_idx + 1;
                if (qual(pix_idx)) qual_n <= qual_n + 1;
                if (fire(pix_idx, qual_n)) begin
                    coord_q.push_back(mk_coord(gen));
                    gen <= gen + 1;
                end
            end
        end
    end
    assign conv_out_valid = v2 ? c2 : spur_en;

    bit mon_en = 1'b0, saw_pix = 1'b0;
    int exp_addr = 0, rd_cnt = 0, done_cnt = 0, done_at = -1, c0 = 0;
    logic [PIX_W-1:0] last_pix = '0;
    logic [10:0] ent;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (img_rd_en) begin
                check_val("rd_addr", img_rd_addr, exp_addr);
                pix_q.push_back(ram[exp_addr % NPIX]);
                exp_addr++;
                rd_cnt++;
            end
            if (cnn_data_in_valid) begin
                if (pix_q.size() == 0) check_val("pix_underflow", 1, 0);
                else check_val("pix_data", cnn_data_in, pix_q.pop_front());
                last_pix = cnn_data_in;
                saw_pix = 1'b1;
            end else if (frame_busy && saw_pix) begin
                check_val("pix_hold", cnn_data_in, last_pix);
            end
            if (out_beat) begin
                if (coord_q.size() == 0) check_val("beat_underflow", 1, 0);
                else begin
                    ent = coord_q.pop_front();
                    if (ent[10]) begin
                        check_val("out_x", out_x, ent[4:0]);
                        check_val("out_y", out_y, ent[9:5]);
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_at = cyc - c0;
            end
        end
    end

    task automatic run_frame(input bit bp, input int mode, input bit spur, input int abort_at,
                             input bit extra_starts, input int exp_done, input int exp_cnt,
                             input bit exp_err);
        bit finished = 1'b0;
        int k;
        @(posedge clk); #1;
        conv_mode = mode; spur_en = spur; model_rst = 1'b1;
        coord_q.delete(); pix_q.delete();
        exp_addr = 0; rd_cnt = 0; done_cnt = 0; done_at = -1;
        @(posedge clk); #1;
        model_rst = 1'b0;
        start = 1'b1; img_rdy = 1'b1; c0 = cyc;
        for (int n = 0; n < 3000 && !finished; n++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            start = extra_starts && (k == 100 || k == 786);
            img_rdy = bp ? (k % 2 == 1) : 1'b1;
            abort = (k == abort_at);
            #1;
            if (k == 1) begin
                check_val("busy_c1", frame_busy, 1);
                check_val("err_clear", frame_err, 0);
            end
            if (k == abort_at) begin
                check_val("abort_rd_en", img_rd_en, 0);
                check_val("abort_pix_vld", cnn_data_in_valid, 0);
            end
            if (abort_at >= 0 && k == abort_at + 1) check_val("abort_idle", frame_busy, 0);
            if (abort_at >= 0 && k == abort_at + 20) begin
                check_val("abort_no_done", done_cnt, 0);
                finished = 1'b1;
            end
            if (abort_at < 0 && done_cnt > 0 && k == done_at + 3) finished = 1'b1;
        end
        start = 1'b0; abort = 1'b0;
        if (!finished) check_val("frame_timeout", 0, 1);
        else if (abort_at < 0) begin
            check_val("done_cycle", done_at, exp_done);
            check_val("done_count", done_cnt, 1);
            check_val("out_cnt", out_cnt, exp_cnt);
            check_val("frame_err", frame_err, exp_err);
            check_val("reads", rd_cnt, NPIX);
            check_val("beats_left", coord_q.size(), 0);
            check_val("idle_after", frame_busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) ram[i] = 8'(i % 256);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_val("reset_state", outs, 0);
        mon_en = 1'b1;

        run_frame(1'b0, 0, 1'b0, -1, 1'b1, 788, NOUT, 1'b0);
        run_frame(1'b0, 1, 1'b0, -1, 1'b0, 785 + DRAIN_MAX, NOUT - 10, 1'b1);
        run_frame(1'b0, 0, 1'b0, 300, 1'b0, 0, 0, 1'b0);
        run_frame(1'b0, 0, 1'b0, -1, 1'b0, 788, NOUT, 1'b0);
        run_frame(1'b1, 0, 1'b1, -1, 1'b0, 788 + 783, NOUT, 1'b0);
        run_frame(1'b0, 2, 1'b0, -1, 1'b0, 787, NOUT, 1'b1);

        mon_en = 1'b0;
        spur_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        #1 check_val("start_abort_busy", frame_busy, 0);
        check_val("start_abort_rd", img_rd_en, 0);
        repeat (3) @(posedge clk);
        #1 check_val("start_abort_idle", frame_busy, 0);

        start = 1'b1; img_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1 check_val("feed_busy", frame_busy, 1);
        #1 rst_n = 1'b0;
        #1 check_val("async_reset", outs, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check_val("post_reset", outs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
